// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage.
//   wb_req_t     : one register-file write request (destination + data)
//   lq_entry_t   : load-queue slot (request + live bit)
//   is_x0()      : true when a destination is the hard-wired zero register
// The request data width is fixed by XLEN_DEFAULT; writeback_stage must be
// built with XLEN equal to it so loads fit the queue slot unchanged.
package wb_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int LQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [4:0]              rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

  typedef struct packed {
    wb_req_t req;
    logic    live;
  } lq_entry_t;

  function automatic logic is_x0(input logic [4:0] rd);
    return (rd == 5'd0);
  endfunction

endpackage

// File: rtl/writeback_stage_load_queue.sv
// Circular FIFO of load results awaiting a register-file write port.
// Ports:
//   clk, rst             clock / async active-high reset
//   push_i, push_entry_i enqueue one entry at the tail (ignored when full)
//   pop_i                dequeue the head (ignored when empty)
//   head_o               current head entry (valid when count_o != 0)
//   count_o              occupied entries
//   kill1_i/kill1_rd_i   clear the live bit of every entry whose rd matches
//   kill2_i/kill2_rd_i   second kill port (one per ALU lane)
module load_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  lq_entry_t              push_entry_i,
  input  logic                   pop_i,
  output lq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  input  logic                   kill1_i,
  input  logic [4:0]             kill1_rd_i,
  input  logic                   kill2_i,
  input  logic [4:0]             kill2_rd_i
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t          req_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // A push into a full queue is refused even if a pop frees a slot this cycle.
  assign push_ok = push_i && (count_q != (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Payload carries no reset; only the live bits and pointers matter after reset.
  always_ff @(posedge clk) begin
    if (push_ok) req_q[wr_ptr_q] <= push_entry_i.req;
  end

  // Kills apply to every slot; empty slots are harmless to clear. The push
  // write comes last so a freshly enqueued entry keeps its computed live bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((kill1_i && (req_q[i].rd == kill1_rd_i)) ||
            (kill2_i && (req_q[i].rd == kill2_rd_i)))
          live_q[i] <= 1'b0;
      end
      if (push_ok) live_q[wr_ptr_q] <= push_entry_i.live;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head_o      = '0;
    head_o.req  = req_q[rd_ptr_q];
    head_o.live = live_q[rd_ptr_q];
  end

  assign count_o = count_q;

endmodule

// File: rtl/writeback_stage.sv
// Dual-issue writeback stage feeding the register file's two write ports.
// Merges ALU lane 1, ALU lane 2 and a queued load stream; stale loads are
// dropped so a younger ALU write to the same register is never overwritten.
// Ports:
//   clk, rst                      clock / async active-high reset
//   alu1_valid/alu1_rd/alu1_data  lane-1 result (always accepted) -> port 1
//   alu2_valid/alu2_rd/alu2_data  lane-2 result (always accepted) -> port 2
//   ld_valid/ld_ready/ld_rd/ld_data  load response handshake
//   reg_write/regd/write_data     write port 1 (registered)
//   reg_write2/regd2/write_data2  write port 2 (registered)
//   lq_count                      load-queue occupancy
// Optional feature (macro WB_FWD_EN): fwd_rs0..3 / fwd_hit / fwd_data0..3
// forward the registered write ports to up to four read operands.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT,
  parameter int XLEN     = XLEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu1_valid,
  input  logic [4:0]                alu1_rd,
  input  logic [XLEN-1:0]           alu1_data,
  input  logic                      alu2_valid,
  input  logic [4:0]                alu2_rd,
  input  logic [XLEN-1:0]           alu2_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [4:0]                ld_rd,
  input  logic [XLEN-1:0]           ld_data,
  output logic                      reg_write,
  output logic [4:0]                regd,
  output logic [XLEN-1:0]           write_data,
  output logic                      reg_write2,
  output logic [4:0]                regd2,
  output logic [XLEN-1:0]           write_data2,
`ifdef WB_FWD_EN
  input  logic [4:0]                fwd_rs0,
  input  logic [4:0]                fwd_rs1,
  input  logic [4:0]                fwd_rs2,
  input  logic [4:0]                fwd_rs3,
  output logic [3:0]                fwd_hit,
  output logic [XLEN-1:0]           fwd_data0,
  output logic [XLEN-1:0]           fwd_data1,
  output logic [XLEN-1:0]           fwd_data2,
  output logic [XLEN-1:0]           fwd_data3,
`endif
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic            a1_ok, a2_ok;
  logic            ld_acc, push, pop;
  lq_entry_t       push_entry, head;
  logic [CW-1:0]   count;
  logic            head_valid, head_hit, head_live;
  logic            ld_p1, ld_p2;

  logic            reg_write_q,  reg_write_d;
  logic [4:0]      regd_q,       regd_d;
  logic [XLEN-1:0] wdata_q,      wdata_d;
  logic            reg_write2_q, reg_write2_d;
  logic [4:0]      regd2_q,      regd2_d;
  logic [XLEN-1:0] wdata2_q,     wdata2_d;

  // Lane acceptance: x0 writes vanish; on a same-rd collision lane 2 wins.
  assign a2_ok = alu2_valid && !is_x0(alu2_rd);
  assign a1_ok = alu1_valid && !is_x0(alu1_rd) && !(a2_ok && (alu1_rd == alu2_rd));

  assign ld_ready = ~rst & (count != CW'(LQ_DEPTH));
  assign ld_acc   = ld_valid & ld_ready;
  // x0 loads complete the handshake but are discarded.
  assign push     = ld_acc & ~is_x0(ld_rd);

  // A load arriving alongside an ALU write to the same rd is the older value.
  always_comb begin
    push_entry          = '0;
    push_entry.req.rd   = ld_rd;
    push_entry.req.data = ld_data;
    push_entry.live     = ~((a1_ok && (alu1_rd == ld_rd)) ||
                            (a2_ok && (alu2_rd == ld_rd)));
  end

  load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .kill1_i      (a1_ok),
    .kill1_rd_i   (alu1_rd),
    .kill2_i      (a2_ok),
    .kill2_rd_i   (alu2_rd)
  );

  // The head is also killed by an ALU write landing in the same cycle, so a
  // popped load can never overtake the newer ALU result.
  assign head_valid = (count != '0);
  assign head_hit   = (a1_ok && (alu1_rd == head.req.rd)) ||
                      (a2_ok && (alu2_rd == head.req.rd));
  assign head_live  = head.live & ~head_hit;

  assign ld_p1 = head_valid & head_live & ~a1_ok;
  assign ld_p2 = head_valid & head_live & a1_ok & ~a2_ok;
  // Dead heads retire without a port.
  assign pop   = head_valid & (~head_live | ~a1_ok | ~a2_ok);

  always_comb begin
    reg_write_d  = 1'b0;
    regd_d       = '0;
    wdata_d      = '0;
    reg_write2_d = 1'b0;
    regd2_d      = '0;
    wdata2_d     = '0;
    if (a1_ok) begin
      reg_write_d = 1'b1;
      regd_d      = alu1_rd;
      wdata_d     = alu1_data;
    end else if (ld_p1) begin
      reg_write_d = 1'b1;
      regd_d      = head.req.rd;
      wdata_d     = head.req.data;
    end
    if (a2_ok) begin
      reg_write2_d = 1'b1;
      regd2_d      = alu2_rd;
      wdata2_d     = alu2_data;
    end else if (ld_p2) begin
      reg_write2_d = 1'b1;
      regd2_d      = head.req.rd;
      wdata2_d     = head.req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      regd_q       <= '0;
      wdata_q      <= '0;
      reg_write2_q <= 1'b0;
      regd2_q      <= '0;
      wdata2_q     <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      regd_q       <= regd_d;
      wdata_q      <= wdata_d;
      reg_write2_q <= reg_write2_d;
      regd2_q      <= regd2_d;
      wdata2_q     <= wdata2_d;
    end
  end

  assign reg_write   = reg_write_q;
  assign regd        = regd_q;
  assign write_data  = wdata_q;
  assign reg_write2  = reg_write2_q;
  assign regd2       = regd2_q;
  assign write_data2 = wdata2_q;
  assign lq_count    = count;

`ifdef WB_FWD_EN
  logic [4:0]      fwd_rs   [4];
  logic [XLEN-1:0] fwd_dat  [4];

  assign fwd_rs[0] = fwd_rs0;
  assign fwd_rs[1] = fwd_rs1;
  assign fwd_rs[2] = fwd_rs2;
  assign fwd_rs[3] = fwd_rs3;

  // Port 2 is checked first so it wins a double match.
  always_comb begin
    fwd_hit = '0;
    for (int k = 0; k < 4; k++) begin
      fwd_dat[k] = '0;
      if (!is_x0(fwd_rs[k])) begin
        if (reg_write2_q && (regd2_q == fwd_rs[k])) begin
          fwd_hit[k] = 1'b1;
          fwd_dat[k] = wdata2_q;
        end else if (reg_write_q && (regd_q == fwd_rs[k])) begin
          fwd_hit[k] = 1'b1;
          fwd_dat[k] = wdata_q;
        end
      end
    end
  end

  assign fwd_data0 = fwd_dat[0];
  assign fwd_data1 = fwd_dat[1];
  assign fwd_data2 = fwd_dat[2];
  assign fwd_data3 = fwd_dat[3];
`endif

endmodule
